// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/redirect controller.
// SYS_XLEN / SYS_REG_AW mirror the system configuration (PC width, GPR
// index width) and are the default parameter values everywhere.
// The FSM state encoding lives here so the bench and any debug logic agree.
package pipe_ctrl_pkg;
  localparam int SYS_XLEN   = 64;
  localparam int SYS_REG_AW = 5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_REDIR    = 2'd2
  } pc_state_e;
endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline control bus: hazard inputs from ID/EX/MEM and stall/flush/
// redirect outputs back to the pipeline registers.
//   master : pipeline side (drives stage info, receives controls)
//   slave  : pipe_ctrl side
// Optional: PIPE_CTRL_PERF_EN adds perf_stall_cyc / perf_flush_cnt (32b).
interface pipe_ctrl_if import pipe_ctrl_pkg::*; #(
  parameter int XLEN   = SYS_XLEN,
  parameter int REG_AW = SYS_REG_AW
);
  logic [REG_AW-1:0] id_rs1_idx, id_rs2_idx;
  logic              id_rs1_used, id_rs2_used;
  logic              ex_valid, ex_is_load;
  logic [REG_AW-1:0] ex_rd_idx;
  logic              ex_redirect;
  logic [XLEN-1:0]   ex_target;
  logic              trap_valid;
  logic [XLEN-1:0]   trap_pc;
  logic              mem_req, mem_ready;
  logic              stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
  logic              flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb;
  logic              redir_valid;
  logic [XLEN-1:0]   redir_pc;
  logic [1:0]        state_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]       perf_stall_cyc, perf_flush_cnt;
`endif

  modport master (
    output id_rs1_idx, id_rs2_idx, id_rs1_used, id_rs2_used,
           ex_valid, ex_is_load, ex_rd_idx, ex_redirect, ex_target,
           trap_valid, trap_pc, mem_req, mem_ready,
    input  stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
           flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb,
           redir_valid, redir_pc, state_o
`ifdef PIPE_CTRL_PERF_EN
          ,perf_stall_cyc, perf_flush_cnt
`endif
  );

  modport slave (
    input  id_rs1_idx, id_rs2_idx, id_rs1_used, id_rs2_used,
           ex_valid, ex_is_load, ex_rd_idx, ex_redirect, ex_target,
           trap_valid, trap_pc, mem_req, mem_ready,
    output stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
           flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb,
           redir_valid, redir_pc, state_o
`ifdef PIPE_CTRL_PERF_EN
          ,perf_stall_cyc, perf_flush_cnt
`endif
  );
endinterface

// File: rtl/pipe_ctrl_hazard_det.sv
// Combinational load-use detector: a load in EX writing a non-zero GPR that
// the ID instruction actually reads.
//   rs1_idx/rs2_idx, rs1_used/rs2_used : ID sources
//   ex_valid, ex_is_load, ex_rd_idx    : EX instruction
//   load_use                           : hazard hit
module pipe_ctrl_hazard_det #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs1_idx,
  input  logic [REG_AW-1:0] rs2_idx,
  input  logic              rs1_used,
  input  logic              rs2_used,
  input  logic              ex_valid,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_rd_idx,
  output logic              load_use
);
  // x0 is hardwired zero, so a load targeting it never creates a hazard.
  assign load_use = ex_valid && ex_is_load && (ex_rd_idx != '0) &&
                    ((rs1_used && (rs1_idx == ex_rd_idx)) ||
                     (rs2_used && (rs2_idx == ex_rd_idx)));
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stalls, flushes and PC redirects.
// Priority: trap > memory wait > EX redirect > load-use.
// Ports: clk, rst (async, active-low), bus (pipe_ctrl_if.slave).
// Optional: PIPE_CTRL_PERF_EN adds stall-cycle / redirect counters.
module pipe_ctrl import pipe_ctrl_pkg::*; #(
  parameter int XLEN   = SYS_XLEN,
  parameter int REG_AW = SYS_REG_AW
) (
  input  logic         clk,
  input  logic         rst,
  pipe_ctrl_if.slave   bus
);
  pc_state_e       state, nxt;
  logic            pend_v, pend_v_nxt;
  logic [XLEN-1:0] pend_t, pend_t_nxt;
  logic            load_use;
  logic [3:0]      stl, fl;   // {pc, if_id, id_ex, ex_mem} / {if_id, id_ex, ex_mem, mem_wb}
  logic            r_v;
  logic [XLEN-1:0] r_pc;

  pipe_ctrl_hazard_det #(.REG_AW(REG_AW)) u_hz (
    .rs1_idx   (bus.id_rs1_idx),
    .rs2_idx   (bus.id_rs2_idx),
    .rs1_used  (bus.id_rs1_used),
    .rs2_used  (bus.id_rs2_used),
    .ex_valid  (bus.ex_valid),
    .ex_is_load(bus.ex_is_load),
    .ex_rd_idx (bus.ex_rd_idx),
    .load_use  (load_use)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_RUN;
      pend_v <= 1'b0;
      pend_t <= '0;
    end else begin
      state  <= nxt;
      pend_v <= pend_v_nxt;
      pend_t <= pend_t_nxt;
    end
  end

  always_comb begin
    nxt        = state;
    pend_v_nxt = pend_v;
    pend_t_nxt = pend_t;
    stl        = 4'b0000;
    fl         = 4'b0000;
    r_v        = 1'b0;
    r_pc       = '0;
    if (bus.trap_valid) begin
      fl         = 4'b1110;
      r_v        = 1'b1;
      r_pc       = bus.trap_pc;
      pend_v_nxt = 1'b0;
      pend_t_nxt = '0;
      nxt        = ST_RUN;
    end else begin
      unique case (state)
        ST_RUN, ST_MEM_WAIT: begin
          if ((state == ST_MEM_WAIT || bus.mem_req) && !bus.mem_ready) begin
            stl = 4'b1111;
            fl  = 4'b0001;
            nxt = ST_MEM_WAIT;
            // First redirect seen while frozen is kept; later ones are the
            // same held EX instruction and must not overwrite it.
            if (bus.ex_redirect && !pend_v) begin
              pend_v_nxt = 1'b1;
              pend_t_nxt = bus.ex_target;
            end
          end else if (state == ST_MEM_WAIT && pend_v) begin
            nxt = ST_REDIR;
          end else begin
            nxt = ST_RUN;
            if (bus.ex_redirect) begin
              fl   = 4'b1100;
              r_v  = 1'b1;
              r_pc = bus.ex_target;
            end else if (load_use && state == ST_RUN) begin
              stl = 4'b1100;
              fl  = 4'b0100;
            end
          end
        end
        ST_REDIR: begin
          fl         = 4'b1100;
          r_v        = 1'b1;
          r_pc       = pend_t;
          pend_v_nxt = 1'b0;
          pend_t_nxt = '0;
          nxt        = ST_RUN;
        end
        default: nxt = ST_RUN;
      endcase
    end
  end

  // Outputs are forced low during reset even though inputs may be active.
  assign bus.stall_pc     = rst & stl[3];
  assign bus.stall_if_id  = rst & stl[2];
  assign bus.stall_id_ex  = rst & stl[1];
  assign bus.stall_ex_mem = rst & stl[0];
  assign bus.flush_if_id  = rst & fl[3];
  assign bus.flush_id_ex  = rst & fl[2];
  assign bus.flush_ex_mem = rst & fl[1];
  assign bus.flush_mem_wb = rst & fl[0];
  assign bus.redir_valid  = rst & r_v;
  assign bus.redir_pc     = rst ? r_pc : '0;
  assign bus.state_o      = rst ? state : ST_RUN;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cyc, flush_cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cyc <= '0;
      flush_cnt <= '0;
    end else begin
      if (stl[3]) stall_cyc <= stall_cyc + 32'd1;
      if (r_v)    flush_cnt <= flush_cnt + 32'd1;
    end
  end
  assign bus.perf_stall_cyc = stall_cyc;
  assign bus.perf_flush_cnt = flush_cnt;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  typedef struct packed {
    logic [4:0]  rs1, rs2;
    logic        u1, u2, exv, exl;
    logic [4:0]  rd;
    logic        exr;
    logic [63:0] tgt;
    logic        trap;
    logic [63:0] tpc;
    logic        mreq, mrdy;
  } in_t;

  typedef struct packed {
    logic [3:0]  stall;  // pc, if_id, id_ex, ex_mem
    logic [3:0]  flush;  // if_id, id_ex, ex_mem, mem_wb
    logic        rv;
    logic [63:0] rpc;
    logic [1:0]  st;
  } out_t;

  typedef struct {
    string name;
    in_t   i;
    out_t  o;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   nchk = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.XLEN(64), .REG_AW(5)) bus ();
  pipe_ctrl #(.XLEN(64), .REG_AW(5)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  // Reference model: "are we frozen on memory", "is a deferred redirect due
  // next cycle", and an optional saved target.
  bit          m_wait, m_redir, m_pv;
  logic [63:0] m_pt;
  bit          n_wait, n_redir, n_pv;
  logic [63:0] n_pt;
  int unsigned m_scyc, m_fcnt;

  function automatic in_t idle();
    in_t i;
    i = '0;
    i.mrdy = 1'b1;
    return i;
  endfunction

  function automatic out_t mo(logic [3:0] s, logic [3:0] f, logic rv, logic [63:0] pc, logic [1:0] st);
    out_t o;
    o.stall = s; o.flush = f; o.rv = rv; o.rpc = pc; o.st = st;
    return o;
  endfunction

  function automatic out_t model_out(in_t i);
    out_t o;
    bit lu;
    o = '0;
    o.st = m_redir ? 2'd2 : (m_wait ? 2'd1 : 2'd0);
    lu = i.exv && i.exl && i.rd != 0 &&
         ((i.u1 && i.rs1 == i.rd) || (i.u2 && i.rs2 == i.rd));
    n_wait = 0; n_redir = 0; n_pv = m_pv; n_pt = m_pt;
    if (i.trap) begin
      o.flush = 4'b1110; o.rv = 1; o.rpc = i.tpc;
      n_pv = 0; n_pt = '0;
    end else if (m_redir) begin
      o.flush = 4'b1100; o.rv = 1; o.rpc = m_pt;
      n_pv = 0; n_pt = '0;
    end else if ((m_wait || i.mreq) && !i.mrdy) begin
      o.stall = 4'b1111; o.flush = 4'b0001;
      n_wait = 1;
      if (i.exr && !m_pv) begin n_pv = 1; n_pt = i.tgt; end
    end else if (m_wait && m_pv) begin
      n_redir = 1;
    end else if (i.exr) begin
      o.flush = 4'b1100; o.rv = 1; o.rpc = i.tgt;
    end else if (lu && !m_wait) begin
      o.stall = 4'b1100; o.flush = 4'b0100;
    end
    return o;
  endfunction

  task automatic model_commit(input out_t o);
    m_wait = n_wait; m_redir = n_redir; m_pv = n_pv; m_pt = n_pt;
    if (o.stall[3]) m_scyc++;
    if (o.rv) m_fcnt++;
  endtask

  task automatic model_reset();
    m_wait = 0; m_redir = 0; m_pv = 0; m_pt = '0; m_scyc = 0; m_fcnt = 0;
  endtask

  task automatic drive(input in_t i);
    bus.id_rs1_idx = i.rs1;  bus.id_rs2_idx = i.rs2;
    bus.id_rs1_used = i.u1;  bus.id_rs2_used = i.u2;
    bus.ex_valid = i.exv;    bus.ex_is_load = i.exl;  bus.ex_rd_idx = i.rd;
    bus.ex_redirect = i.exr; bus.ex_target = i.tgt;
    bus.trap_valid = i.trap; bus.trap_pc = i.tpc;
    bus.mem_req = i.mreq;    bus.mem_ready = i.mrdy;
  endtask

  function automatic out_t read_dut();
    out_t a;
    a.stall = {bus.stall_pc, bus.stall_if_id, bus.stall_id_ex, bus.stall_ex_mem};
    a.flush = {bus.flush_if_id, bus.flush_id_ex, bus.flush_ex_mem, bus.flush_mem_wb};
    a.rv    = bus.redir_valid;
    a.rpc   = bus.redir_pc;
    a.st    = bus.state_o;
    return a;
  endfunction

  task automatic chk(input string name, input out_t a, input out_t e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got stall=%b flush=%b rv=%b pc=%h st=%0d, want stall=%b flush=%b rv=%b pc=%h st=%0d",
               name, a.stall, a.flush, a.rv, a.rpc, a.st, e.stall, e.flush, e.rv, e.rpc, e.st);
    end
  endtask

  task automatic chk_v(input string name, input logic [63:0] got, input logic [63:0] want);
    nchk++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // One clock: drive, compare against model mid-cycle, advance.
  task automatic step(input in_t i, input string name, output out_t a);
    out_t e;
    drive(i);
    #2;
    e = model_out(i);
    a = read_dut();
    chk(name, a, e);
    @(posedge clk);
    model_commit(e);
    #1;
  endtask

  task automatic do_reset(input in_t i, input string name);
    drive(i);
    rst = 1'b0;
    #2;
    chk(name, read_dut(), '0);
`ifdef PIPE_CTRL_PERF_EN
    chk_v({name, "_perf_stall"}, 64'(bus.perf_stall_cyc), 64'd0);
    chk_v({name, "_perf_flush"}, 64'(bus.perf_flush_cnt), 64'd0);
`endif
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  vec_t vt[12];

  initial begin
    in_t  i;
    out_t a, e;

    for (int k = 0; k < 12; k++) vt[k].i = idle();
    vt[0].name = "idle";
    vt[0].o = mo(4'b0000, 4'b0000, 0, 64'h0, 2'd0);
    vt[1].name = "lu_rs1_x5";
    vt[1].i.exv = 1; vt[1].i.exl = 1; vt[1].i.rd = 5; vt[1].i.rs1 = 5; vt[1].i.u1 = 1;
    vt[1].o = mo(4'b1100, 4'b0100, 0, 64'h0, 2'd0);
    vt[2].name = "lu_rs2_x7";
    vt[2].i.exv = 1; vt[2].i.exl = 1; vt[2].i.rd = 7; vt[2].i.rs2 = 7; vt[2].i.u2 = 1; vt[2].i.rs1 = 3; vt[2].i.u1 = 1;
    vt[2].o = mo(4'b1100, 4'b0100, 0, 64'h0, 2'd0);
    vt[3].name = "lu_rs1_unused";
    vt[3].i.exv = 1; vt[3].i.exl = 1; vt[3].i.rd = 5; vt[3].i.rs1 = 5; vt[3].i.u1 = 0;
    vt[3].o = mo(4'b0000, 4'b0000, 0, 64'h0, 2'd0);
    vt[4].name = "lu_x0";
    vt[4].i.exv = 1; vt[4].i.exl = 1; vt[4].i.rd = 0; vt[4].i.rs1 = 0; vt[4].i.u1 = 1;
    vt[4].o = mo(4'b0000, 4'b0000, 0, 64'h0, 2'd0);
    vt[5].name = "lu_ex_invalid";
    vt[5].i.exv = 0; vt[5].i.exl = 1; vt[5].i.rd = 5; vt[5].i.rs1 = 5; vt[5].i.u1 = 1;
    vt[5].o = mo(4'b0000, 4'b0000, 0, 64'h0, 2'd0);
    vt[6].name = "lu_not_load";
    vt[6].i.exv = 1; vt[6].i.exl = 0; vt[6].i.rd = 5; vt[6].i.rs1 = 5; vt[6].i.u1 = 1;
    vt[6].o = mo(4'b0000, 4'b0000, 0, 64'h0, 2'd0);
    vt[7].name = "lu_vs_redirect";
    vt[7].i.exv = 1; vt[7].i.exl = 1; vt[7].i.rd = 5; vt[7].i.rs1 = 5; vt[7].i.u1 = 1;
    vt[7].i.exr = 1; vt[7].i.tgt = 64'h1000;
    vt[7].o = mo(4'b0000, 4'b1100, 1, 64'h1000, 2'd0);
    vt[8].name = "mem_req_ready";
    vt[8].i.mreq = 1; vt[8].i.mrdy = 1;
    vt[8].o = mo(4'b0000, 4'b0000, 0, 64'h0, 2'd0);
    vt[9].name = "ex_redirect";
    vt[9].i.exr = 1; vt[9].i.tgt = 64'h8000_0200;
    vt[9].o = mo(4'b0000, 4'b1100, 1, 64'h8000_0200, 2'd0);
    vt[10].name = "trap_run";
    vt[10].i.trap = 1; vt[10].i.tpc = 64'h8000_0004;
    vt[10].o = mo(4'b0000, 4'b1110, 1, 64'h8000_0004, 2'd0);
    vt[11].name = "trap_beats_all";
    vt[11].i = vt[7].i; vt[11].i.mreq = 1; vt[11].i.mrdy = 0;
    vt[11].i.trap = 1; vt[11].i.tpc = 64'h0000_0040;
    vt[11].o = mo(4'b0000, 4'b1110, 1, 64'h40, 2'd0);

    drive(idle());
    model_reset();
    #12;
    do_reset(idle(), "reset_idle");

    // Single-cycle vectors from RUN; each leaves the FSM in RUN.
    for (int k = 0; k < 12; k++) begin
      drive(vt[k].i);
      #2;
      e = model_out(vt[k].i);
      chk(vt[k].name, read_dut(), vt[k].o);
      @(posedge clk);
      model_commit(e);
      #1;
    end

    // Memory wait: 3 cycles not ready, then ready.
    do_reset(idle(), "reset_seq1");
    i = idle(); i.mreq = 1; i.mrdy = 0;
    for (int c = 0; c < 3; c++) begin
      step(i, "mw_wait", a);
      chk_v("mw_stall_all", 64'(a.stall), 64'hF);
      chk_v("mw_state", 64'(a.st), (c == 0) ? 64'd0 : 64'd1);
    end
    i.mrdy = 1;
    step(i, "mw_release", a);
    chk_v("mw_rel_stall", 64'(a.stall), 64'h0);
    chk_v("mw_rel_state", 64'(a.st), 64'd1);
    step(idle(), "mw_after", a);
    chk_v("mw_after_state", 64'(a.st), 64'd0);

    // Redirect during wait is deferred until one cycle after exit.
    i = idle(); i.mreq = 1; i.mrdy = 0;
    step(i, "dr_w1", a);
    i.exr = 1; i.tgt = 64'h8000_0100;
    step(i, "dr_w2", a);
    chk_v("dr_w2_norv", 64'(a.rv), 64'd0);
    i.tgt = 64'hDEAD_BEEF;
    step(i, "dr_w3", a);
    i = idle();
    step(i, "dr_exit", a);
    chk_v("dr_exit_norv", 64'(a.rv), 64'd0);
    step(idle(), "dr_redir", a);
    chk_v("dr_redir_rv", 64'(a.rv), 64'd1);
    chk_v("dr_redir_pc", a.rpc, 64'h8000_0100);
    chk_v("dr_redir_st", 64'(a.st), 64'd2);
    step(idle(), "dr_done", a);
    chk_v("dr_done_rv", 64'(a.rv), 64'd0);

    // Trap during wait with a pending redirect.
    i = idle(); i.mreq = 1; i.mrdy = 0; i.exr = 1; i.tgt = 64'h8000_0100;
    step(i, "tw_w1", a);
    i.exr = 0;
    step(i, "tw_w2", a);
    i.trap = 1; i.tpc = 64'h8000_0004;
    step(i, "tw_trap", a);
    chk_v("tw_trap_pc", a.rpc, 64'h8000_0004);
    chk_v("tw_trap_fl", 64'(a.flush), 64'hE);
    step(idle(), "tw_after", a);
    chk_v("tw_after_st", 64'(a.st), 64'd0);
    step(idle(), "tw_after2", a);
    chk_v("tw_no_pend", 64'(a.rv), 64'd0);

    // Reset mid-wait with a pending redirect.
    i = idle(); i.mreq = 1; i.mrdy = 0; i.exr = 1; i.tgt = 64'h1234;
    step(i, "rw_w1", a);
    step(i, "rw_w2", a);
    do_reset(i, "reset_midwait");
    for (int c = 0; c < 3; c++) step(idle(), "rw_after", a);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      i = idle();
      i.rs1  = 5'($urandom_range(0, 3));
      i.rs2  = 5'($urandom_range(0, 3));
      i.u1   = 1'($urandom_range(0, 1));
      i.u2   = 1'($urandom_range(0, 1));
      i.exv  = 1'($urandom_range(0, 1));
      i.exl  = 1'($urandom_range(0, 1));
      i.rd   = 5'($urandom_range(0, 3));
      i.exr  = ($urandom_range(0, 5) == 0);
      i.tgt  = {$urandom, $urandom};
      i.trap = ($urandom_range(0, 40) == 0);
      i.tpc  = {$urandom, $urandom};
      i.mreq = ($urandom_range(0, 3) == 0);
      i.mrdy = ($urandom_range(0, 2) != 0);
      step(i, "rand", a);
    end
`ifdef PIPE_CTRL_PERF_EN
    #2;
    chk_v("perf_stall_cyc", 64'(bus.perf_stall_cyc), 64'(m_scyc));
    chk_v("perf_flush_cnt", 64'(bus.perf_flush_cnt), 64'(m_fcnt));
`endif
    do_reset(idle(), "reset_end");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL take parameter XLEN, default 64: PC/target width.
REQ-002 SHALL take parameter REG_AW, default 5: GPR index width.
REQ-003 SHALL have port clk  in  1: sole clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1: reset, asynchronous, active-low.
REQ-005 SHALL have ports id_rs1_idx, id_rs2_idx  in  REG_AW: ID-stage source indices.
REQ-006 SHALL have ports id_rs1_used, id_rs2_used  in  1: the ID instruction reads that source.
REQ-007 SHALL have ports ex_valid, ex_is_load  in  1, and ex_rd_idx  in  REG_AW: EX-stage instruction info.
REQ-008 SHALL have ports ex_redirect  in  1 and ex_target  in  XLEN: branch/jump taken in EX.
REQ-009 SHALL have ports trap_valid  in  1 and trap_pc  in  XLEN: trap/mret redirect from clint, MEM stage.
REQ-010 SHALL have ports mem_req, mem_ready  in  1: data-memory access in MEM and its completion.
REQ-011 SHALL have outputs stall_pc, stall_if_id, stall_id_ex, stall_ex_mem  out  1: hold the named register.
REQ-012 SHALL have outputs flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb  out  1: load a bubble into the named register.
REQ-013 SHALL have outputs redir_valid  out  1 and redir_pc  out  XLEN: PC override.
REQ-014 SHALL have output state_o  out  2: current FSM state.

Function
REQ-015 SHALL implement states RUN=0, MEM_WAIT=1, REDIR=2, encoded as stated.
REQ-016 Priority each cycle SHALL be: trap > memory wait > EX redirect > load-use.
REQ-017 Trap, in any state: assert flush_if_id, flush_id_ex, flush_ex_mem, and redir_valid with redir_pc=trap_pc, same cycle; clear the pending redirect; next state RUN.
REQ-018 RUN with mem_req=1 and mem_ready=0: assert all four stalls plus flush_mem_wb; next state MEM_WAIT.
REQ-019 MEM_WAIT: keep those outputs while mem_ready=0; on mem_ready=1 release all stalls that cycle.
REQ-020 MEM_WAIT exit SHALL go to REDIR if a redirect is pending, else RUN.
REQ-021 ex_redirect=1 while stalled for memory: latch ex_target into a pending register once; later ex_redirect pulses do not overwrite it; no redirect output yet.
REQ-022 REDIR: assert redir_valid with redir_pc=pending target, plus flush_if_id and flush_id_ex, for exactly one cycle; next state RUN.
REQ-023 RUN with ex_redirect=1: assert redir_valid (redir_pc=ex_target), flush_if_id and flush_id_ex, same cycle.
REQ-024 Load-use in RUN: ex_valid & ex_is_load & ex_rd_idx!=0 & ((id_rs1_used & rs1 match) | (id_rs2_used & rs2 match)).
REQ-025 Load-use SHALL assert stall_pc, stall_if_id and flush_id_ex for one cycle, unless ex_redirect=1, in which case the redirect wins.
REQ-026 Outputs not asserted by a rule above SHALL be 0; redir_pc SHALL be 0 whenever redir_valid=0.
REQ-027 mem_req=1 with mem_ready=1 in the same RUN cycle SHALL cause no stall.

Reset
REQ-028 rst=0 SHALL force state RUN, clear the pending redirect valid flag and target, and zero the perf counters, immediately.
REQ-029 While rst=0, all outputs SHALL be 0.
REQ-030 Reset during MEM_WAIT SHALL discard the wait and any pending redirect.

Configuration
REQ-031 Macro PIPE_CTRL_PERF_EN defined: add outputs perf_stall_cyc and perf_flush_cnt, 32 bits each.
REQ-032 perf_stall_cyc counts cycles with stall_pc=1; perf_flush_cnt counts cycles with redir_valid=1; both wrap at 2^32.
REQ-033 PIPE_CTRL_PERF_EN undefined: neither port nor counter logic SHALL exist; all other behaviour is identical.

Structure
REQ-034 The state enum and encodings SHALL live in the shared package; XLEN and REG_AW SHALL come from sysconfig.
REQ-035 Sub-module hazard_det (combinational load-use compare) is natural; the FSM stays in pipe_ctrl.

Verification
REQ-036 Load x5 in EX, ID reads rs1=5 -> one cycle of stall_pc=stall_if_id=flush_id_ex=1, then normal flow.
REQ-037 Load x0 in EX, ID reads rs1=0 -> no stall.
REQ-038 mem_req=1 with mem_ready low 3 cycles -> state_o=1 for 3 cycles, all stalls high; released on the mem_ready cycle.
REQ-039 ex_redirect=1 to 0x8000_0100 in cycle 2 of a wait -> redir_valid only in the cycle after exit, redir_pc=0x8000_0100.
REQ-040 trap_valid=1 to 0x8000_0004 during MEM_WAIT with a pending redirect -> same-cycle redirect to 0x8000_0004, next state RUN, pending redirect dropped.
REQ-041 rst low mid-wait -> outputs 0 immediately, state_o=0; with PIPE_CTRL_PERF_EN defined, counters read 0.
